// File: rtl/packet_sink_pkg.sv
// Shared NoC definitions for the packet sink and its peers.
// Holds FSM encoding, counter widths and header field layout.
package packet_sink_pkg;

  typedef enum logic {
    HEAD = 1'b0,
    BODY = 1'b1
  } sink_state_e;

  localparam int PKT_CNT_W   = 16;
  localparam int ERR_CNT_W   = 8;
  localparam int HDR_DST_LSB = 0;

endpackage

// File: rtl/packet_sink_if.sv
// Two-phase flit channel between a packet source and a sink.
// req toggles once per flit; ack toggles once per accepted flit.
interface packet_sink_if #(
  parameter int SIZE = 8
) ();

  logic            ch_req;
  logic            ch_ack;
  logic [SIZE-1:0] ch_flit;

  modport master (
    output ch_req,
    output ch_flit,
    input  ch_ack
  );

  modport slave (
    input  ch_req,
    input  ch_flit,
    output ch_ack
  );

endinterface

// File: rtl/packet_sink_chan_rx_ctrl.sv
// Two-phase channel acceptance: pending detect, ack toggle, stall.
// accept is held off on the edge that releases reset.
module chan_rx_ctrl #(
  parameter int STALL = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic req,
  output logic ack,
  output logic accept
);

  localparam int SW = (STALL > 0) ? $clog2(STALL + 1) : 1;

  logic [SW-1:0] stall_q;
  logic          run_q;

  assign accept = run_q && (req != ack) && (stall_q == '0);

  // ack toggles per accept; stall counter gates the next one
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ack     <= 1'b0;
      stall_q <= '0;
      run_q   <= 1'b0;
    end else begin
      run_q <= 1'b1;
      if (accept) begin
        ack     <= ~ack;
        stall_q <= SW'(STALL);
      end else if (stall_q != '0) begin
        stall_q <= stall_q - 1'b1;
      end
    end
  end

endmodule

// File: rtl/packet_sink.sv
// Packet sink: header check, payload XOR, packet/error counters.
// Results are published the cycle after the last flit lands.
module packet_sink
  import packet_sink_pkg::*;
#(
  parameter int ID               = 1,
  parameter int DESTINATION_BITS = 1,
  parameter int FLITS            = 8,
  parameter int SIZE             = 8,
  parameter int STALL            = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  packet_sink_if.slave         ch,
  output logic                 pkt_valid,
  output logic                 pkt_dst_ok,
  output logic [SIZE-1:0]      pkt_xsum,
  output logic [PKT_CNT_W-1:0] pkt_count,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic                 busy
);

  localparam int IW = (FLITS > 2) ? $clog2(FLITS) : 1;
  localparam logic [DESTINATION_BITS-1:0] MY_ID =
    DESTINATION_BITS'(ID);
  localparam logic [IW-1:0] LAST = IW'(FLITS - 1);
  localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;

  logic            accept;
  sink_state_e     state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            dst_q, dst_d;
  logic [SIZE-1:0] xsum_q, xsum_d;
  logic            fin_q, fin_d;
  logic            hdr_ok;

  chan_rx_ctrl #(
    .STALL (STALL)
  ) u_rx (
    .clk    (clk),
    .reset  (reset),
    .req    (ch.ch_req),
    .ack    (ch.ch_ack),
    .accept (accept)
  );

  assign hdr_ok =
    ch.ch_flit[HDR_DST_LSB +: DESTINATION_BITS] == MY_ID;
  assign busy = (state_q == BODY);

  // packet state, flit index, running XOR and header verdict
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= HEAD;
      idx_q   <= '0;
      dst_q   <= 1'b0;
      xsum_q  <= '0;
      fin_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      dst_q   <= dst_d;
      xsum_q  <= xsum_d;
      fin_q   <= fin_d;
    end
  end

  // next-state: header latches verdict, body folds flits into XOR
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    dst_d   = dst_q;
    xsum_d  = xsum_q;
    fin_d   = 1'b0;
    unique case (state_q)
      HEAD: begin
        if (accept) begin
          dst_d   = hdr_ok;
          xsum_d  = '0;
          idx_d   = IW'(1);
          state_d = BODY;
        end
      end
      BODY: begin
        if (accept) begin
          xsum_d = xsum_q ^ ch.ch_flit;
          if (idx_q == LAST) begin
            idx_d   = '0;
            state_d = HEAD;
            fin_d   = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // publish packet results and update counters one cycle later
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pkt_valid  <= 1'b0;
      pkt_dst_ok <= 1'b0;
      pkt_xsum   <= '0;
      pkt_count  <= '0;
      err_count  <= '0;
    end else begin
      pkt_valid <= fin_q;
      if (fin_q) begin
        pkt_dst_ok <= dst_q;
        pkt_xsum   <= xsum_q;
        pkt_count  <= pkt_count + 1'b1;
        if (!dst_q && err_count != ERR_MAX)
          err_count <= err_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_packet_sink.sv
// Bench for packet_sink: per-cycle model compare on a STALL=0 sink
// plus accept-spacing checks on a STALL=3 sink.
module tb_packet_sink;
  import packet_sink_pkg::*;

  localparam int MY_ID  = 1;
  localparam int D_MASK = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b;
  packet_sink_if #(.SIZE(8)) ch_a ();
  packet_sink_if #(.SIZE(8)) ch_b ();

  logic        va, dsta, busya;
  logic [7:0]  xa, erra;
  logic [15:0] cnta;
  logic        vb, dstb, busyb;
  logic [7:0]  xb, errb;
  logic [15:0] cntb;

  packet_sink #(
    .ID(1), .DESTINATION_BITS(1), .FLITS(8),
    .SIZE(8), .STALL(0)
  ) dut_a (
    .clk(clk), .reset(rst_a), .ch(ch_a),
    .pkt_valid(va), .pkt_dst_ok(dsta), .pkt_xsum(xa),
    .pkt_count(cnta), .err_count(erra), .busy(busya)
  );

  packet_sink #(
    .ID(1), .DESTINATION_BITS(1), .FLITS(8),
    .SIZE(8), .STALL(3)
  ) dut_b (
    .clk(clk), .reset(rst_b), .ch(ch_b),
    .pkt_valid(vb), .pkt_dst_ok(dstb), .pkt_xsum(xb),
    .pkt_count(cntb), .err_count(errb), .busy(busyb)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // model of sink A, driven only by what the bench sends
  int e_ack, e_valid, e_dst, e_xsum, e_count, e_err, e_busy;
  int m_idx, m_dst, m_x;
  bit pend, acc_next, chk_en;
  logic [7:0] acc_flit;

  initial begin
    e_ack = 0; e_valid = 0; e_dst = 0; e_xsum = 0;
    e_count = 0; e_err = 0; e_busy = 0;
    m_idx = 0; m_dst = 0; m_x = 0;
    pend = 0; acc_next = 0; chk_en = 0;
  end

  task automatic model_clear();
    e_ack = 0; e_valid = 0; e_dst = 0; e_xsum = 0;
    e_count = 0; e_err = 0; e_busy = 0;
    m_idx = 0; m_dst = 0; m_x = 0;
    pend = 0; acc_next = 0;
  endtask

  always @(posedge clk) begin
    #1;
    if (rst_a) begin
      e_valid = 0;
      if (pend) begin
        e_valid = 1;
        e_dst   = m_dst;
        e_xsum  = m_x;
        e_count = (e_count + 1) % 65536;
        if (m_dst == 0 && e_err < 255) e_err++;
        pend = 0;
      end
      if (acc_next) begin
        acc_next = 0;
        e_ack ^= 1;
        if (m_idx == 0) begin
          m_dst = ((acc_flit & D_MASK) == (MY_ID & D_MASK));
          m_x   = 0;
          m_idx = 1;
        end else begin
          m_x ^= acc_flit;
          m_idx++;
          if (m_idx == 8) begin
            m_idx = 0;
            pend  = 1;
          end
        end
        e_busy = (m_idx != 0);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en && rst_a) begin
      chk("a_ack", 32'(ch_a.ch_ack), e_ack);
      chk("a_valid", 32'(va), e_valid);
      chk("a_busy", 32'(busya), e_busy);
      chk("a_count", 32'(cnta), e_count);
      chk("a_err", 32'(erra), e_err);
      chk("a_dst", 32'(dsta), e_dst);
      chk("a_xsum", 32'(xa), e_xsum);
    end
  end

  // source A reacts a cycle after ack, giving 2-cycle flit spacing
  task automatic send_a(input logic [7:0] f);
    @(posedge clk);
    #2;
    ch_a.ch_flit = f;
    ch_a.ch_req  = ~ch_a.ch_req;
    acc_flit = f;
    acc_next = 1;
    @(posedge clk);
  endtask

  task automatic send_pkt_a(input logic [7:0] hdr,
                            input logic [7:0] pl[7]);
    send_a(hdr);
    for (int i = 0; i < 7; i++) send_a(pl[i]);
  endtask

  task automatic zero_chk_a(input string tag);
    chk({tag, "_ack"}, 32'(ch_a.ch_ack), 0);
    chk({tag, "_valid"}, 32'(va), 0);
    chk({tag, "_dst"}, 32'(dsta), 0);
    chk({tag, "_xsum"}, 32'(xa), 0);
    chk({tag, "_count"}, 32'(cnta), 0);
    chk({tag, "_err"}, 32'(erra), 0);
    chk({tag, "_busy"}, 32'(busya), 0);
  endtask

  task automatic reset_a(input string tag);
    @(posedge clk);
    #2;
    rst_a = 1'b0;
    ch_a.ch_req = 1'b0;
    model_clear();
    #1;
    zero_chk_a(tag);
    @(posedge clk);
    #2;
    rst_a = 1'b1;
  endtask

  // accept-spacing monitor for sink B
  int cyc = 0;
  int last_b = 0;
  int nacc_b = 0;
  logic prev_ack_b = 1'b0;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst_b) begin
      if (ch_b.ch_ack != prev_ack_b) begin
        if (nacc_b > 0) chk("b_gap", 32'(cyc - last_b), 4);
        last_b = cyc;
        nacc_b++;
      end
      prev_ack_b = ch_b.ch_ack;
    end
  end

  // eager source B: toggles req right after each ack, mid-stall
  task automatic send_b(input logic [7:0] f);
    int n;
    n = 0;
    while (ch_b.ch_req != ch_b.ch_ack && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 20) begin
      errors++;
      checks++;
      $display("FAIL b_wait: got timeout expected ack");
    end
    ch_b.ch_flit = f;
    ch_b.ch_req  = ~ch_b.ch_req;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [7:0] pl[7];

  initial begin
    rst_a = 1'b0;
    rst_b = 1'b0;
    ch_a.ch_req = 1'b0;
    ch_a.ch_flit = '0;
    ch_b.ch_req = 1'b0;
    ch_b.ch_flit = '0;
    repeat (2) @(posedge clk);
    #1;
    zero_chk_a("rst0");
    @(posedge clk);
    #2;
    rst_a = 1'b1;
    rst_b = 1'b1;
    chk_en = 1;

    // matching header, mixed payload
    for (int i = 0; i < 7; i++) pl[i] = 8'h10 + 8'(i);
    send_pkt_a(8'h01, pl);
    repeat (3) @(negedge clk);
    chk("p1_dst", 32'(dsta), 1);
    chk("p1_count", 32'(cnta), 1);
    chk("p1_err", 32'(erra), 0);
    chk("p1_xsum", 32'(xa), 32'h17);
    chk("p1_busy", 32'(busya), 0);

    // mismatching header, walking-one payload
    reset_a("rst1");
    for (int i = 0; i < 7; i++) pl[i] = 8'(1 << i);
    send_pkt_a(8'h00, pl);
    repeat (3) @(negedge clk);
    chk("p2_dst", 32'(dsta), 0);
    chk("p2_err", 32'(erra), 1);
    chk("p2_count", 32'(cnta), 1);
    chk("p2_xsum", 32'(xa), 32'h7F);

    // reset mid-packet discards partial flits
    reset_a("rst2");
    send_a(8'h01);
    send_a(8'h55);
    send_a(8'h66);
    send_a(8'h77);
    reset_a("rst_mid");
    for (int i = 0; i < 7; i++) pl[i] = 8'hAA;
    send_pkt_a(8'h03, pl);
    repeat (3) @(negedge clk);
    chk("p3_count", 32'(cnta), 1);
    chk("p3_dst", 32'(dsta), 1);
    chk("p3_xsum", 32'(xa), 32'hAA);
    chk("p3_err", 32'(erra), 0);

    // error counter saturation
    reset_a("rst3");
    for (int k = 0; k < 256; k++) begin
      for (int i = 0; i < 7; i++) pl[i] = 8'(k);
      send_pkt_a(8'h02, pl);
    end
    repeat (3) @(negedge clk);
    chk("sat_err", 32'(erra), 255);
    chk("sat_count", 32'(cnta), 256);

    // stalled sink B
    send_b(8'h01);
    for (int i = 0; i < 7; i++) send_b(8'(1 << i));
    repeat (12) @(negedge clk);
    chk("b_accepts", 32'(nacc_b), 8);
    chk("b_count", 32'(cntb), 1);
    chk("b_xsum", 32'(xb), 32'h7F);
    chk("b_dst", 32'(dstb), 1);
    chk("b_busy", 32'(busyb), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
